// File: rtl/exec_pipe_alu_mul.sv
// exec_pipe_alu_mul -- single-issue execute stage with a 1-cycle ALU and a
// fully pipelined MUL_LAT-cycle multiplier that share one result port.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               kills every in-flight op, including the one presented
//                       in the same cycle
//   in_valid/in_fu      op presented this cycle; in_fu 0 = ALU, 1 = MUL
//   in_op/in_tag        operation select and ROB tag
//   in1, in2            operands
//   busy                combinational; 1 = an ALU op presented now is dropped
//                       because a MUL already owns next cycle's result slot
//   out_valid/out_tag/out_data
//                       registered result; tag/data hold while out_valid=0
//
// Result-slot bookkeeping: slot_q[i] = 1 means the result port is owned in
// cycle "now + i". Bit 0 is therefore the current output's valid bit, bit 1
// is the slot an ALU issued now would need, and a MUL issued now claims the
// slot MUL_LAT cycles ahead by entering at the top of the shift register.
module exec_pipe_alu_mul #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_fu,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  output logic             busy,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_data
);

  localparam int SHW  = $clog2(XLEN);
  // Multiplier register stages between issue and the output register.
  localparam int NSTG = MUL_LAT - 1;

  logic [MUL_LAT-1:0] slot_q, slot_d;

  logic alu_accept;
  logic mul_issue;
  logic mul_done;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [XLEN-1:0]   mul_res;

  // Stage 0 is the newest MUL op, stage NSTG-1 feeds the output register.
  // Validity of each stage lives in slot_q, so only tag/data are staged here.
  logic [TAG_W-1:0] stg_tag_q  [NSTG];
  logic [TAG_W-1:0] stg_tag_d  [NSTG];
  logic [XLEN-1:0]  stg_data_q [NSTG];
  logic [XLEN-1:0]  stg_data_d [NSTG];

  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [XLEN-1:0]  out_data_q, out_data_d;

  assign busy      = slot_q[1];
  assign out_valid = slot_q[0];
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;

  // A flush in the same cycle suppresses both the new op and the MUL that
  // would otherwise retire into the output register.
  assign alu_accept = in_valid & ~in_fu & ~busy & ~flush;
  assign mul_issue  = in_valid &  in_fu & ~flush;
  assign mul_done   = slot_q[1] & ~flush;

  // ALU datapath
  always_comb begin
    shamt   = in2[SHW-1:0];
    alu_res = '0;
    case (in_op)
      4'd0:    alu_res = in1 + in2;
      4'd1:    alu_res = in1 - in2;
      4'd2:    alu_res = in1 & in2;
      4'd3:    alu_res = in1 | in2;
      4'd4:    alu_res = in1 ^ in2;
      4'd5:    alu_res = in1 << shamt;
      4'd6:    alu_res = in1 >> shamt;
      4'd7:    alu_res = $signed(in1) >>> shamt;
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
      default: alu_res = '0;
    endcase
  end

  // Multiplier datapath. Operands are extended to 2*XLEN (sign or zero as
  // the op demands); the product modulo 2^(2*XLEN) is then exact for every
  // signedness combination, so one unsigned multiplier covers all four ops.
  always_comb begin
    mul_a    = {{XLEN{(in_op != 4'd3) & in1[XLEN-1]}}, in1};
    mul_b    = {{XLEN{(in_op == 4'd1) & in2[XLEN-1]}}, in2};
    mul_prod = mul_a * mul_b;
    case (in_op)
      4'd0:                mul_res = mul_prod[XLEN-1:0];
      4'd1, 4'd2, 4'd3:    mul_res = mul_prod[2*XLEN-1:XLEN];
      default:             mul_res = '0;
    endcase
  end

  // Slot shift register: every bit moves one cycle closer each clock. An
  // accepted ALU op claims next cycle's slot, which busy guarantees is free.
  always_comb begin
    slot_d    = {mul_issue, slot_q[MUL_LAT-1:1]};
    slot_d[0] = slot_q[1] | alu_accept;
    if (flush) begin
      slot_d = '0;
    end
  end

  always_comb begin
    stg_tag_d[0]  = in_tag;
    stg_data_d[0] = mul_res;
    for (int i = 1; i < NSTG; i++) begin
      stg_tag_d[i]  = stg_tag_q[i-1];
      stg_data_d[i] = stg_data_q[i-1];
    end
  end

  always_comb begin
    out_tag_d  = out_tag_q;
    out_data_d = out_data_q;
    if (alu_accept) begin
      out_tag_d  = in_tag;
      out_data_d = alu_res;
    end else if (mul_done) begin
      out_tag_d  = stg_tag_q[NSTG-1];
      out_data_d = stg_data_q[NSTG-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q     <= '0;
      out_tag_q  <= '0;
      out_data_q <= '0;
      for (int i = 0; i < NSTG; i++) begin
        stg_tag_q[i]  <= '0;
        stg_data_q[i] <= '0;
      end
    end else begin
      slot_q     <= slot_d;
      out_tag_q  <= out_tag_d;
      out_data_q <= out_data_d;
      for (int i = 0; i < NSTG; i++) begin
        stg_tag_q[i]  <= stg_tag_d[i];
        stg_data_q[i] <= stg_data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_exec_pipe_alu_mul.sv
// tb_exec_pipe_alu_mul -- directed bench for exec_pipe_alu_mul with a
// scoreboard: each accepted op pushes its expected tag/data and the cycle it
// must appear in; every clock the bench compares out_* and busy against it.
module tb_exec_pipe_alu_mul;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 3;
  localparam int TAG_W   = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_fu = 1'b0;
  logic [3:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [XLEN-1:0]  in1 = '0;
  logic [XLEN-1:0]  in2 = '0;
  logic             busy;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_data;

  exec_pipe_alu_mul #(
    .XLEN   (XLEN),
    .MUL_LAT(MUL_LAT),
    .TAG_W  (TAG_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_fu    (in_fu),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .out_valid(out_valid),
    .out_tag  (out_tag),
    .out_data (out_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  logic [TAG_W-1:0] last_tag = '0;
  logic [XLEN-1:0]  last_data = '0;

  function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    longint sa;
    longint sh;
    sa = longint'($signed(a));
    sh = longint'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return XLEN'(sa >>> sh);
      4'd8: return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] mul_ref(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [63:0] p;
    logic [63:0] ua;
    logic [63:0] ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd0: begin p = ua * ub; return p[31:0]; end
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      4'd2: begin p = longint'($signed(a)) * longint'(ub); return p[63:32]; end
      4'd3: begin p = ua * ub; return p[63:32]; end
      default: return '0;
    endcase
  endfunction

  // A MUL owns next cycle's slot exactly when one is due then.
  function automatic logic busy_model();
    foreach (sb[i]) begin
      if (sb[i].due == cyc + 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    in_valid = 1'b0;
    flush    = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_tag", 64'(out_tag), 64'(e.tag));
      chk("out_data", 64'(out_data), 64'(e.data));
      last_tag  = e.tag;
      last_data = e.data;
      $display("cycle %0d: result tag=%0d data=%08h", cyc, out_tag, out_data);
    end else begin
      chk("out_valid_idle", 64'(out_valid), 64'd0);
      chk("out_tag_hold", 64'(out_tag), 64'(last_tag));
      chk("out_data_hold", 64'(out_data), 64'(last_data));
    end
    chk("busy", 64'(busy), 64'(busy_model()));
  endtask

  task automatic issue(input logic fu, input logic [3:0] op, input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic do_flush);
    exp_t e;
    int   pos;
    in_valid = 1'b1;
    in_fu    = fu;
    in_op    = op;
    in_tag   = tag;
    in1      = a;
    in2      = b;
    flush    = do_flush;
    if (do_flush) begin
      sb.delete();
    end else if (fu) begin
      e.due = cyc + MUL_LAT; e.tag = tag; e.data = mul_ref(op, a, b);
      sb.push_back(e);
    end else if (!busy_model()) begin
      e.due = cyc + 1; e.tag = tag; e.data = alu_ref(op, a, b);
      pos = sb.size();
      while (pos > 0 && sb[pos-1].due > e.due) pos--;
      sb.insert(pos, e);
    end else begin
      $display("cycle %0d: ALU tag=%0d refused (busy)", cyc, tag);
    end
    tick();
  endtask

  task automatic idle_junk();
    in_valid = 1'b0;
    in_fu    = 1'($urandom);
    in_op    = 4'($urandom);
    in_tag   = TAG_W'($urandom);
    in1      = $urandom;
    in2      = $urandom;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
    end
    reset = 1'b0;
    sb.delete();
    last_tag  = '0;
    last_data = '0;
    chk("busy_after_reset", 64'(busy), 64'd0);
  endtask

  initial begin
    do_reset(2);

    // ALU directed corner cases
    issue(1'b0, 4'd0, 6'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(1'b0, 4'd7, 6'd6, 32'h8000_0000, 32'd4, 1'b0);
    issue(1'b0, 4'd1, 6'd7, 32'd0, 32'd1, 1'b0);
    issue(1'b0, 4'd8, 6'd8, 32'h8000_0000, 32'd1, 1'b0);
    issue(1'b0, 4'd9, 6'd9, 32'h8000_0000, 32'd1, 1'b0);
    issue(1'b0, 4'd5, 6'd10, 32'h0000_0001, 32'h0000_003F, 1'b0);
    // every ALU code, including the reserved ones
    for (int op = 0; op < 16; op++) begin
      issue(1'b0, 4'(op), TAG_W'(op), $urandom, $urandom, 1'b0);
    end
    idle_junk();
    idle_junk();

    // MUL directed values and reserved codes
    issue(1'b1, 4'd1, 6'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, 4'd3, 6'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, 4'd2, 6'd12, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(1'b1, 4'd0, 6'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    issue(1'b1, 4'd9, 6'd14, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    issue(1'b1, 4'd2, 6'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain();

    // ALU colliding with a MUL result slot, then retried
    issue(1'b1, 4'd0, 6'd20, 32'd7, 32'd9, 1'b0);
    repeat (MUL_LAT - 2) tick();
    chk("busy_conflict", 64'(busy), 64'd1);
    issue(1'b0, 4'd0, 6'd21, 32'd1, 32'd2, 1'b0);
    chk("busy_retry", 64'(busy), 64'd0);
    issue(1'b0, 4'd0, 6'd21, 32'd1, 32'd2, 1'b0);
    drain();

    // ten back-to-back MULs
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 4'($urandom_range(0, 3)), TAG_W'(i), $urandom, $urandom, 1'b0);
    end
    drain();

    // flush with two MULs in flight and an ALU presented in the flush cycle
    issue(1'b1, 4'd1, 6'd30, $urandom, $urandom, 1'b0);
    issue(1'b1, 4'd3, 6'd31, $urandom, $urandom, 1'b0);
    issue(1'b0, 4'd0, 6'd32, 32'd1, 32'd1, 1'b1);
    chk("busy_after_flush", 64'(busy), 64'd0);
    repeat (MUL_LAT) tick();
    issue(1'b0, 4'd4, 6'd33, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    drain();

    // reset pulse with MULs in flight
    issue(1'b1, 4'd0, 6'd40, $urandom, $urandom, 1'b0);
    issue(1'b1, 4'd3, 6'd41, $urandom, $urandom, 1'b0);
    do_reset(1);
    repeat (MUL_LAT + 2) tick();

    // random mix; the model decides which ALU ops get refused
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 4'($urandom_range(0, 11)), TAG_W'(i), $urandom, $urandom, 1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_pipe_alu_mul.md
EXEC_PIPE_ALU_MUL -- requirements
Module: exec_pipe_alu_mul

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 The block SHALL have parameter MUL_LAT, default 3, multiplier issue-to-result latency in cycles; legal range 2..8.
REQ-003 The block SHALL have parameter TAG_W, default 6, width of the ROB tag carried with each op.

Ports:
REQ-004 clock  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  kill all in-flight ops, including any op issued in the same cycle.
REQ-007 in_valid  in  1  op presented this cycle.
REQ-008 in_fu  in  1  functional unit: 0 = ALU, 1 = MUL.
REQ-009 in_op  in  4  operation select.
REQ-010 in_tag  in  TAG_W  ROB tag.
REQ-011 in1, in2  in  XLEN  operands.
REQ-012 busy  out  1  combinational; 1 = an ALU issue this cycle is refused.
REQ-013 out_valid  out  1  result valid, registered.
REQ-014 out_tag  out  TAG_W  tag of the result.
REQ-015 out_data  out  XLEN  result.

Function
REQ-016 ALU ops SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU; codes 10-15 SHALL produce 0.
REQ-017 Shift amounts SHALL use in2[$clog2(XLEN)-1:0]; ADD/SUB SHALL wrap modulo 2^XLEN; SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-018 MUL ops SHALL be: 0 MUL (low XLEN of product), 1 MULH (signed x signed, high), 2 MULHSU (signed in1 x unsigned in2, high), 3 MULHU (unsigned x unsigned, high); codes 4-15 SHALL produce 0.
REQ-019 An ALU op accepted at cycle t SHALL appear on out_* at cycle t+1.
REQ-020 A MUL op accepted at cycle t SHALL appear on out_* at cycle t+MUL_LAT; the multiplier SHALL be fully pipelined and accept one op per cycle.
REQ-021 The block SHALL track result-slot reservations in a MUL_LAT-deep shift register advanced every cycle; each MUL issue reserves the slot MUL_LAT cycles ahead.
REQ-022 busy SHALL be 1 exactly when the slot for cycle t+1 is reserved by an in-flight MUL.
REQ-023 An ALU op with in_valid=1 while busy=1 SHALL be discarded: no result and no state change.
REQ-024 MUL issues SHALL never be refused; busy SHALL NOT gate them.
REQ-025 At most one op SHALL complete per cycle; out_valid=0 in cycles with no completing op.
REQ-026 out_tag and out_data SHALL hold their previous values when out_valid=0.
REQ-027 When flush=1 at cycle t, all reservations and in-flight ops, including any op presented at t, SHALL be invalidated; out_valid SHALL be 0 from t+1 until a post-flush op completes.
REQ-028 flush SHALL NOT clear out_tag or out_data.
REQ-029 busy SHALL be 0 in the cycle after flush.
REQ-030 in_fu, in_op, in_tag, in1 and in2 SHALL be ignored when in_valid=0.

Reset
REQ-031 While reset=1, all reservations and pipeline valid bits SHALL clear; out_valid=0, out_tag=0, out_data=0.
REQ-032 busy SHALL be 0 in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight ops; none SHALL ever emerge.

Verification
REQ-034 ALU ADD 0xFFFFFFFF + 1, tag 5, at t -> at t+1: out_valid=1, out_tag=5, out_data=0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-035 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULHU of the same operands -> 0xFFFFFFFE; MULHSU -0x1 x 0x2 -> 0xFFFFFFFF; each appears exactly MUL_LAT cycles after issue.
REQ-036 MUL at t, ALU attempted at t+MUL_LAT-1 -> busy=1 and ALU dropped; MUL result at t+MUL_LAT; retrying the ALU at t+MUL_LAT is accepted, result at t+MUL_LAT+1.
REQ-037 MUL back-to-back every cycle for 10 cycles, tags 0-9 -> 10 consecutive results, tags in order, no gaps.
REQ-038 Two MULs in flight, flush asserted together with a new ALU issue -> out_valid stays 0 for MUL_LAT+1 cycles; busy=0 in the next cycle.
REQ-039 Reset asserted for 1 cycle with MUL ops in flight -> out_valid=0, out_tag=0, out_data=0 afterwards; no stale result ever emerges.
